qpsk_dibit_splitter: RTL and testbench

//   QPSK serial-to-parallel front end. Packs the serial bit stream into dibits
//   (first bit = I -> data_0, second bit = Q -> data_1) and holds each dibit
//   for one symbol period of SYM_CLKS clocks.

---
 rtl/qpsk_dibit_splitter.sv | 135 +++++++++++++
 tb/tb_qpsk_dibit_splitter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_dibit_splitter.sv
// QPSK serial-to-parallel front end: packs serial bits into I/Q dibits
// and times each symbol period for the downstream selector and mapper.
module qpsk_dibit_splitter #(
  parameter int SYM_CLKS = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  input  logic bit_valid,
  output logic data_0,
  output logic data_1,
  output logic sel,
  output logic sym_en,
  output logic sym_strobe,
  output logic underrun,
  output logic overrun
);

  typedef enum logic {S_I = 1'b0, S_Q = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SYM_CLKS / 2);

  state_t           state_q, state_d;
  logic             i_hold_q, i_hold_d;
  logic             data0_q, data0_d;
  logic             data1_q, data1_d;
  logic             sel_q, sel_d;
  logic             sym_en_q, sym_en_d;
  logic             strobe_q, strobe_d;
  logic             undr_q, undr_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             load;

  assign load    = en && bit_valid && (state_q == S_Q);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_I;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_I;
    end else if (bit_valid) begin
      state_d = (state_q == S_I) ? S_Q : S_I;
    end
  end

  always_comb begin
    i_hold_d = i_hold_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    sel_d    = sel_q;
    sym_en_d = sym_en_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    strobe_d = 1'b0;
    undr_d   = 1'b0;
    if (!en) begin
      i_hold_d = 1'b0;
      data0_d  = 1'b0;
      data1_d  = 1'b0;
      sel_d    = 1'b0;
      sym_en_d = 1'b0;
      cnt_d    = '0;
    end else begin
      if (bit_valid && state_q == S_I) i_hold_d = bit_in;
      if (load) begin
        data0_d  = i_hold_q;
        data1_d  = bit_in;
        strobe_d = 1'b1;
        sym_en_d = 1'b1;
        cnt_d    = '0;
        sel_d    = 1'b0;
        // a dibit landing before the last clock cuts the symbol short
        if (sym_en_q && cnt_q != LAST) ovr_d = 1'b1;
      end else if (sym_en_q) begin
        if (cnt_q == LAST) begin
          sym_en_d = 1'b0;
          sel_d    = 1'b0;
          cnt_d    = '0;
          undr_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          sel_d = (cnt_inc >= HALF);
        end
      end else begin
        cnt_d = '0;
        sel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold_q <= 1'b0;
      data0_q  <= 1'b0;
      data1_q  <= 1'b0;
      sel_q    <= 1'b0;
      sym_en_q <= 1'b0;
      strobe_q <= 1'b0;
      undr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      i_hold_q <= i_hold_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      sel_q    <= sel_d;
      sym_en_q <= sym_en_d;
      strobe_q <= strobe_d;
      undr_q   <= undr_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    data_0     = data0_q;
    data_1     = data1_q;
    sel        = sel_q;
    sym_en     = sym_en_q;
    sym_strobe = strobe_q;
    underrun   = undr_q;
    overrun    = ovr_q;
  end

endmodule

// File: tb/tb_qpsk_dibit_splitter.sv
// Directed bench for qpsk_dibit_splitter; outputs packed as
// {data_0,data_1,sel,sym_en,sym_strobe,underrun,overrun}.
module tb_qpsk_dibit_splitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic data_0, data_1, sel, sym_en;
  logic sym_strobe, underrun, overrun;

  int total = 0;
  int bad = 0;

  qpsk_dibit_splitter #(.SYM_CLKS(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .data_0(data_0),
    .data_1(data_1),
    .sel(sel),
    .sym_en(sym_en),
    .sym_strobe(sym_strobe),
    .underrun(underrun),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {data_0, data_1, sel, sym_en,
                    sym_strobe, underrun, overrun};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    bit_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== 7'b0000000) begin
      bad++;
      $display("FAIL reset obs=%b exp=%b", obs, 7'b0);
    end
  endtask

  task automatic test_single();
    logic [6:0] exp;
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    total++;
    if (obs !== 7'b1001100) begin
      bad++;
      $display("FAIL single_load obs=%b exp=%b", obs, 7'b1001100);
    end
    for (int c = 1; c <= 7; c++) begin
      step();
      exp = {2'b10, (c >= 4), 4'b1000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single_cnt%0d obs=%b exp=%b", c, obs, exp);
      end
    end
    step();
    total++;
    if (obs !== 7'b1000010) begin
      bad++;
      $display("FAIL expiry obs=%b exp=%b", obs, 7'b1000010);
    end
    step();
    total++;
    if (obs !== 7'b1000000) begin
      bad++;
      $display("FAIL expiry_after obs=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int errs;
    bits = 8'b11011000;
    errs = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[7-i]);
      if (i % 2 == 1) begin
        total++;
        if ({data_0, data_1, sym_strobe} !==
            {bits[8-i], bits[7-i], 1'b1}) begin
          bad++;
          $display("FAIL b2b_dibit%0d obs=%b%b%b exp=%b%b1",
                   i / 2, data_0, data_1, sym_strobe,
                   bits[8-i], bits[7-i]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        if (i >= 1 && (sym_en !== 1'b1 || underrun !== 1'b0 ||
                       overrun !== 1'b0)) errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL b2b_continuity errs=%0d exp=0", errs);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    step();
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (obs !== 7'b1101101) begin
      bad++;
      $display("FAIL overrun_load obs=%b exp=%b", obs, 7'b1101101);
    end
    step();
    step();
    step();
    total++;
    if (obs !== 7'b1101001) begin
      bad++;
      $display("FAIL overrun_cnt3 obs=%b exp=%b", obs, 7'b1101001);
    end
    step();
    total++;
    if (obs !== 7'b1111001) begin
      bad++;
      $display("FAIL overrun_cnt4 obs=%b exp=%b", obs, 7'b1111001);
    end
    for (int k = 0; k < 6; k++) step();
    total++;
    if (obs !== 7'b1100001) begin
      bad++;
      $display("FAIL overrun_sticky obs=%b exp=%b", obs, 7'b1100001);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear obs=%b exp=0", overrun);
    end
  endtask

  task automatic test_enable();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    en = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    step();
    step();
    bit_valid = 1'b0;
    total++;
    if (obs !== 7'b0000000) begin
      bad++;
      $display("FAIL en_flush obs=%b exp=%b", obs, 7'b0);
    end
    en = 1'b1;
    send_bit(1'b0);
    total++;
    if (obs !== 7'b0000000) begin
      bad++;
      $display("FAIL en_no_load obs=%b exp=%b", obs, 7'b0);
    end
    send_bit(1'b1);
    total++;
    if (obs !== 7'b0101100) begin
      bad++;
      $display("FAIL en_reload obs=%b exp=%b", obs, 7'b0101100);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    for (int k = 0; k < 5; k++) step();
    total++;
    if (obs !== 7'b1111000) begin
      bad++;
      $display("FAIL rstmid_pre obs=%b exp=%b", obs, 7'b1111000);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (obs !== 7'b0000000) begin
      bad++;
      $display("FAIL rstmid obs=%b exp=%b", obs, 7'b0);
    end
    step();
    total++;
    if (obs !== 7'b0000000) begin
      bad++;
      $display("FAIL rstmid_after obs=%b exp=%b", obs, 7'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_enable();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
